// File: rtl/vecmac_accum.sv
// Purpose: accumulate 4-lane unsigned product beats into saturating dot-product results.
// Latency: a beat carrying in_last at edge T presents its result with out_valid high after edge T+2.
// Backpressure: input is never stalled; a completed result meeting a full, unready output register is dropped and flagged.
module vecmac_accum #(
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [63:0]      in_product,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             err_overrun,
    output logic             err_proto
);

    // One registered beat: flags are already qualified by in_valid.
    typedef struct packed {
        logic        vld;
        logic        first;
        logic        last;
        logic [17:0] sum;
    } beat_t;

    typedef enum logic {
        IDLE = 1'b0,
        OPEN = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [ACC_W-1:0] ACC_MAX = {ACC_W{1'b1}};

    beat_t              s1;
    logic [17:0]        lane_sum;

    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic               sat;
    logic               done;

    logic [ACC_W-1:0]   sum_ext;
    logic [ACC_W:0]     acc_wide;
    logic               acc_ovf;
    logic [ACC_W-1:0]   acc_add;
    logic [CNT_W-1:0]   cnt_inc;
    logic               start_new;

    // Four 16-bit lanes summed into 18 bits; the widest possible sum still fits.
    always_comb begin
        lane_sum = {2'b00, in_product[15:0]}
                 + {2'b00, in_product[31:16]}
                 + {2'b00, in_product[47:32]}
                 + {2'b00, in_product[63:48]};
    end

    // Stage 1: capture the lane sum with its beat flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1 <= '0;
        end else begin
            s1.vld   <= in_valid;
            s1.first <= in_valid & in_first;
            s1.last  <= in_valid & in_last;
            s1.sum   <= lane_sum;
        end
    end

    // Saturating accumulate and beat-count arithmetic for an open dot product.
    always_comb begin
        sum_ext   = {{(ACC_W-18){1'b0}}, s1.sum};
        acc_wide  = {1'b0, acc} + {1'b0, sum_ext};
        acc_ovf   = acc_wide[ACC_W];
        acc_add   = acc_ovf ? ACC_MAX : acc_wide[ACC_W-1:0];
        cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
        start_new = (state == IDLE) || s1.first;
    end

    // Stage 2 / FSM: fold each beat into ACC/CNT and pulse done when a result completes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            sat       <= 1'b0;
            done      <= 1'b0;
            err_proto <= 1'b0;
        end else begin
            done <= s1.vld & s1.last;
            if (s1.vld) begin
                if (start_new) begin
                    // A first while open throws away the partial sum.
                    acc <= sum_ext;
                    cnt <= CNT_ONE;
                    sat <= 1'b0;
                    if ((state == OPEN) && s1.first) begin
                        err_proto <= 1'b1;
                    end
                end else begin
                    acc <= acc_add;
                    cnt <= cnt_inc;
                    sat <= sat | acc_ovf;
                end
                state <= s1.last ? IDLE : OPEN;
            end
        end
    end

    // Output register: load when empty or draining this cycle, otherwise drop and flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_acc     <= '0;
            out_count   <= '0;
            out_sat     <= 1'b0;
            err_overrun <= 1'b0;
        end else if (done && (!out_valid || out_ready)) begin
            out_valid <= 1'b1;
            out_acc   <= acc;
            out_count <= cnt;
            out_sat   <= sat;
        end else if (done) begin
            err_overrun <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/vecmac_accum.md
VECMAC_ACCUM -- requirements
Module: vecmac_accum

Interface
REQ-001 Parameter ACC_W, default 32: accumulator/result width, legal range 20..48.
REQ-002 Parameter CNT_W, default 16: beat-counter width.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low; sampled on rising edge of clk.
REQ-005 in_valid  input  1  product beat present; every beat SHALL be accepted (no upstream backpressure).
REQ-006 in_product  input  64  unsigned products {p3,p2,p1,p0}, 16 bits each, lane0 in [15:0].
REQ-007 in_first  input  1  beat starts a new dot product; qualified by in_valid.
REQ-008 in_last  input  1  beat ends current dot product; qualified by in_valid.
REQ-009 out_valid  output  1  result held in output register.
REQ-010 out_ready  input  1  consumer accepts result when out_valid and out_ready both high.
REQ-011 out_acc  output  ACC_W  accumulated dot-product result.
REQ-012 out_count  output  CNT_W  number of beats in that result.
REQ-013 out_sat  output  1  result saturated (travels with out_acc).
REQ-014 err_overrun  output  1  sticky: a result was dropped because output register was full.
REQ-015 err_proto  output  1  sticky: in_first received while a dot product was open.

Function
REQ-016 Stage 1 SHALL register lane sum S = p0+p1+p2+p3 as 18-bit unsigned (max 260100, no overflow) with its valid/first/last flags.
REQ-017 Stage 2 SHALL add S into accumulator ACC (ACC_W bits, zero-extended) and increment beat count CNT.
REQ-018 FSM states IDLE and OPEN; reset state IDLE.
REQ-019 IDLE: any stage-1 valid beat SHALL load ACC=S, CNT=1 regardless of in_first; go OPEN unless last.
REQ-020 OPEN: valid beat without first SHALL do ACC=ACC+S, CNT=CNT+1.
REQ-021 OPEN: valid beat with first SHALL discard partial sum, load ACC=S, CNT=1, set err_proto.
REQ-022 Beat with last (any state) SHALL complete the result after applying that beat and return FSM to IDLE; first and last on one beat gives a 1-beat result.
REQ-023 If ACC+S exceeds 2^ACC_W-1, ACC SHALL clamp to 2^ACC_W-1 and a per-result sat flag SHALL set; flag clears when a new result starts.
REQ-024 CNT SHALL saturate at 2^CNT_W-1.
REQ-025 Latency: beat with in_last sampled at edge T SHALL yield out_valid high after edge T+2.
REQ-026 Output register: loads completed result when empty, or when out_valid&out_ready in the same cycle (old drains, new loads, no bubble).
REQ-027 Completed result arriving while out_valid=1 and out_ready=0 SHALL be dropped, output register unchanged, err_overrun set.
REQ-028 out_acc/out_count/out_sat SHALL remain stable while out_valid=1 and out_ready=0.
REQ-029 out_valid SHALL clear after a handshake with no new result loading.
REQ-030 in_valid low cycles inside an open dot product SHALL leave ACC/CNT unchanged.

Reset
REQ-031 rst_n=0 at an edge SHALL clear both pipeline stages, ACC, CNT, FSM to IDLE, out_valid=0, out_acc=0, out_count=0, out_sat=0, err_overrun=0, err_proto=0.
REQ-032 Reset mid dot product SHALL discard all partial state; in-flight beats SHALL produce no result.
REQ-033 Sticky errors SHALL clear only by reset.

Verification
REQ-034 4 beats, products all lanes 0x0010 (S=64), first on beat0, last on beat3, out_ready=1 -> out_acc=256, out_count=4, out_sat=0, out_valid 2 cycles after last.
REQ-035 Single beat first+last, lanes 0xFE01 each -> out_acc=260100, out_count=1.
REQ-036 ACC_W=20, 5 beats of S=260100 -> out_acc=0xFFFFF, out_sat=1; next result with S=1 -> out_sat=0.
REQ-037 out_ready=0, two back-to-back 1-beat results (S=10, S=20) -> out_acc holds 10, err_overrun=1; after out_ready=1 out_valid drops, 20 never appears.
REQ-038 first on beat0 (S=5), first again on beat1 (S=7), last on beat2 (S=3) -> out_acc=10, out_count=2, err_proto=1.
REQ-039 rst_n low for one edge after 2 beats of an open product, then 1-beat first+last S=9 -> single result out_acc=9, out_count=1, errors 0.
